// File: rtl/decode_stage_pkg.sv
// Shared opcode, format and bundle-layout definitions for the decode stage.
package decode_stage_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   localparam int INST_W = 32;
   localparam int FMT_W  = 3;
   // Bundle = {pc, illegal, fmt, imm, inst}; imm and pc widths are added by the user.
   localparam int BUNDLE_BASE_W = INST_W + FMT_W + 1;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational format classifier and sign-extended immediate builder.
module imm_gen
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]      inst_i,
   output fmt_e             fmt_o,
   output logic [XLEN-1:0]  imm_o,
   output logic             illegal_o
);

   logic signed [31:0] imm32_s;

   assign imm_o = XLEN'(imm32_s);

   // Opcode decode selects the format and the immediate bit arrangement.
   always_comb begin
      fmt_o     = FMT_ILL;
      imm32_s   = 32'sd0;
      illegal_o = 1'b0;
      case (inst_i[6:0])
         OPC_OP: fmt_o = FMT_R;
         OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: begin
            fmt_o   = FMT_I;
            imm32_s = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         OPC_STORE: begin
            fmt_o   = FMT_S;
            imm32_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         end
         OPC_BRANCH: begin
            fmt_o   = FMT_B;
            imm32_s = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                       inst_i[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt_o   = FMT_U;
            imm32_s = {inst_i[31:12], 12'd0};
         end
         OPC_JAL: begin
            fmt_o   = FMT_J;
            imm32_s = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                       inst_i[30:21], 1'b0};
         end
         default: begin
            fmt_o     = FMT_ILL;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RISC-V decode stage with a 2-entry skid buffer.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_inst,
   input  logic [PC_WIDTH-1:0] in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_WIDTH-1:0] out_pc,
   output logic [6:0]          out_opcode,
   output logic [4:0]          out_rd,
   output logic [2:0]          out_func3,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [6:0]          out_func7,
   output logic [2:0]          out_fmt,
   output logic [XLEN-1:0]     out_imm,
   output logic                out_illegal
);

   localparam int IMM_LSB = INST_W;
   localparam int FMT_LSB = IMM_LSB + XLEN;
   localparam int ILL_BIT = FMT_LSB + FMT_W;
   localparam int PC_LSB  = ILL_BIT + 1;
   localparam int BW      = BUNDLE_BASE_W + XLEN + PC_WIDTH;

   fmt_e            dec_fmt_s;
   logic [XLEN-1:0] dec_imm_s;
   logic            dec_illegal_s;
   logic [BW-1:0]   new_bundle_s;
   logic            in_xfer_s;
   logic            out_xfer_s;

   logic            out_valid_q, out_valid_d;
   logic            skid_valid_q, skid_valid_d;
   logic            in_ready_q, in_ready_d;
   logic [BW-1:0]   out_data_q, out_data_d;
   logic [BW-1:0]   skid_data_q, skid_data_d;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst_i    (in_inst),
      .fmt_o     (dec_fmt_s),
      .imm_o     (dec_imm_s),
      .illegal_o (dec_illegal_s)
   );

   assign new_bundle_s = {in_pc, dec_illegal_s, dec_fmt_s, dec_imm_s, in_inst};
   assign in_xfer_s    = in_valid & in_ready_q;
   assign out_xfer_s   = out_valid_q & out_ready;

   // Skid-buffer next state; flush wins over any transfer in the same cycle.
   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_data_d   = out_data_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         if (out_xfer_s) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            skid_valid_d = 1'b1;
         end
      end else if (out_valid_q) begin
         if (out_xfer_s && in_xfer_s) begin
            out_data_d = new_bundle_s;
         end else if (out_xfer_s) begin
            out_valid_d = 1'b0;
         end else if (in_xfer_s) begin
            skid_data_d  = new_bundle_s;
            skid_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b1;
         end
      end else begin
         if (in_xfer_s) begin
            out_data_d  = new_bundle_s;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end
      in_ready_d = ~skid_valid_d;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         out_data_q   <= out_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_pc      = out_data_q[PC_LSB +: PC_WIDTH];
   assign out_illegal = out_data_q[ILL_BIT];
   assign out_fmt     = out_data_q[FMT_LSB +: FMT_W];
   assign out_imm     = out_data_q[IMM_LSB +: XLEN];
   assign out_opcode  = out_data_q[6:0];
   assign out_rd      = out_data_q[11:7];
   assign out_func3   = out_data_q[14:12];
   assign out_rs1     = out_data_q[19:15];
   assign out_rs2     = out_data_q[24:20];
   assign out_func7   = out_data_q[31:25];

endmodule

// File: tb/tb_decode_stage.sv
// Randomised scoreboard bench for decode_stage against a spec-level model.
module tb_decode_stage;

   bit          clk;
   logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [31:0] in_inst = 32'd0, in_pc = 32'd0;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_pc, out_imm;
   logic [6:0]  out_opcode, out_func7;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_func3, out_fmt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [2:0]  fmt;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   exp_t sb_q[$];
   bit   armed = 1'b0;
   bit   just_reset = 1'b0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_func3(out_func3),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func7(out_func7),
      .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sext(input longint raw, input int bits);
      longint half;
      half = longint'(1) << (bits - 1);
      return (raw >= half) ? raw - (half * 2) : raw;
   endfunction

   // Reference decode computed arithmetically from the field definitions.
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
      exp_t   e;
      longint v;
      e.pc = pc; e.inst = i; e.ill = 1'b0; v = 0;
      case (i[6:0])
         7'h33: e.fmt = 3'd0;
         7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
            e.fmt = 3'd1; v = sext(longint'(i[31:20]), 12);
         end
         7'h23: begin
            e.fmt = 3'd2; v = sext(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
         end
         7'h63: begin
            e.fmt = 3'd3;
            v = sext(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                     longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
         end
         7'h37, 7'h17: begin
            e.fmt = 3'd4; v = longint'(i[31:12]) * 4096;
         end
         7'h6F: begin
            e.fmt = 3'd5;
            v = sext(longint'(i[31]) * (longint'(1) << 20) + longint'(i[19:12]) * 4096 +
                     longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
         end
         default: begin
            e.fmt = 3'd7; e.ill = 1'b1;
         end
      endcase
      e.imm = 32'(v);
      return e;
   endfunction

   // Monitor: checks the presented state, then applies the coming edge to the model.
   always @(negedge clk) begin
      #2;
      if (armed) begin
         chk("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
         chk("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
         if (just_reset) begin
            chk("rst_data", {out_pc, out_imm}, 64'd0);
            chk("rst_fields", {out_opcode, out_rd, out_func3, out_rs1, out_rs2,
                               out_func7, out_fmt, out_illegal}, 64'd0);
         end
         if (out_valid && sb_q.size() > 0) begin
            chk("pc", 64'(out_pc), 64'(sb_q[0].pc));
            chk("fields", {out_func7, out_rs2, out_rs1, out_func3, out_rd, out_opcode},
                64'(sb_q[0].inst));
            chk("fmt_ill", {out_fmt, out_illegal}, {sb_q[0].fmt, sb_q[0].ill});
            chk("imm", 64'(out_imm), 64'(sb_q[0].imm));
         end
      end
      if (rst) begin
         sb_q.delete();
         armed = 1'b1;
         just_reset = 1'b1;
      end else begin
         just_reset = 1'b0;
         if (flush) begin
            sb_q.delete();
         end else begin
            if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (in_valid && in_ready) sb_q.push_back(model(in_inst, in_pc));
         end
      end
   end

   task automatic send(input logic [31:0] inst, input logic [31:0] pc);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_inst = inst; in_pc = pc;
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] ops [12];
      logic [31:0] r;
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
      return r;
   endfunction

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed decodes with out_ready=1.
      send(32'h00500093, 32'h100); #3;
      chk("addi_valid", 64'(out_valid), 64'd1);
      chk("addi", {out_opcode, out_rd, out_rs1, out_fmt, out_imm},
          {7'h13, 5'd1, 5'd0, 3'd1, 32'd5});
      send(32'hFE21AE23, 32'h104); #3;
      chk("sw", {out_fmt, out_rs1, out_rs2, out_func3, out_imm},
          {3'd2, 5'd3, 5'd2, 3'd2, 32'hFFFFFFFC});
      send(32'hFE000CE3, 32'h108); #3;
      chk("beq", {out_fmt, out_imm}, {3'd3, 32'hFFFFFFF8});
      send(32'h123452B7, 32'h10C); #3;
      chk("lui", {out_fmt, out_rd, out_imm}, {3'd4, 5'd5, 32'h12345000});
      send(32'h0000007F, 32'h110); #3;
      chk("ill", {out_illegal, out_fmt, out_imm, out_func7}, {1'b1, 3'd7, 32'd0, 7'd0});

      // Backpressure: A, B accepted; C held off until out_ready rises.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h00A00093; in_pc = 32'h200;
      @(negedge clk); in_inst = 32'h00B00113; in_pc = 32'h204;
      @(negedge clk); in_inst = 32'h00C00193; in_pc = 32'h208;
      #3; chk("bp_full", 64'(in_ready), 64'd0);
      repeat (2) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk); #1;
      while (!in_ready) begin @(negedge clk); #1; end
      @(negedge clk); in_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Flush while FULL with a new input offered.
      out_ready = 1'b0;
      send(32'h00100213, 32'h300);
      send(32'h00200293, 32'h304);
      in_valid = 1'b1; in_inst = 32'h00300313; in_pc = 32'h308; flush = 1'b1;
      @(negedge clk); flush = 1'b0; in_valid = 1'b0;
      #3; chk("flush", {out_valid, in_ready}, 2'b01);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset in the middle of traffic.
      out_ready = 1'b0;
      send(32'h00400393, 32'h400);
      send(32'h00500413, 32'h404);
      rst = 1'b1; in_valid = 1'b1;
      @(negedge clk); rst = 1'b0; in_valid = 1'b0;
      #3; chk("mid_rst", {out_valid, in_ready}, 2'b01);

      // Random traffic with backpressure, flushes and occasional reset.
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_inst   = rand_inst();
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         rst       = ($urandom_range(0, 149) == 0);
      end

      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
      repeat (6) @(negedge clk);
      #3; chk("drain", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RISC-V instruction decode stage: the next generation of the combinational field splitter.
- Splits the instruction into its fields, classifies its format, builds the sign-extended immediate, and flags unsupported opcodes.
- Sits between fetch and register-read/execute; a 2-entry skid buffer gives full throughput and a registered upstream ready.

Parameters:
- XLEN, 32, width of the sign-extended immediate output (>=32).
- PC_WIDTH, 32, width of the PC carried alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drops every held instruction this cycle.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept; registered (skid buffer empty).
- in_inst  input  32  raw instruction.
- in_pc  input  PC_WIDTH  PC of in_inst.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- out_pc  output  PC_WIDTH  PC carried through unchanged.
- out_opcode  output  7  inst[6:0].
- out_rd  output  5  inst[11:7].
- out_func3  output  3  inst[14:12].
- out_rs1  output  5  inst[19:15].
- out_rs2  output  5  inst[24:20].
- out_func7  output  7  inst[31:25].
- out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_imm  output  XLEN  sign-extended immediate.
- out_illegal  output  1  opcode not in the supported set.

Behaviour:
- Reset (rst=1 at the edge): out_valid=0, skid entry invalid, in_ready=1. All data outputs reset to 0.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Payload is held stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 instruction/cycle while out_ready=1.
- Decode is combinational on the incoming instruction; the result is registered into the output or skid entry.
- Buffer states, named by (out_valid, skid_valid):
  - EMPTY (0,0): input transfer -> ONE.
  - ONE (1,0):
    - Output transfer with input transfer -> stays ONE, output reloaded.
    - Output transfer only -> EMPTY.
    - Input transfer without output transfer -> FULL; new bundle goes to the skid entry.
  - FULL (1,1): in_ready=0. Output transfer -> skid moves to output -> ONE.
- in_ready is a register equal to ~skid_valid_next. It never depends combinationally on out_ready.
- Instruction order is preserved in all cases.
- flush:
  - Clears out_valid and skid_valid at the edge.
  - Any input transfer in the same cycle is discarded.
  - in_ready=1 the next cycle.
  - rst has priority over flush.
- Format by opcode:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Anything else -> ILL, with out_illegal=1.
- Immediate construction, sign-extended from inst[31] to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and ILL: imm = 0.
- Raw fields are always driven from the instruction bits, even for ILL.

Decomposition:
- Shared package holds:
  - opcode localparams (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL);
  - FMT_* codes;
  - the bundle width constant.
- One combinational sub-module, imm_gen (instruction, XLEN -> fmt, imm, illegal), instantiated once ahead of the buffer.
- The buffer logic stays in decode_stage.

Test Plan:
- Reset, then in 0x00500093 (addi x1,x0,5) with out_ready=1. Next cycle: out_valid=1, opcode=0x13, rd=1, rs1=0, fmt=I, imm=5.
- 0xFE21AE23 (sw x2,-4(x3)) -> fmt=S, rs1=3, rs2=2, func3=2, imm=0xFFFFFFFC.
- 0xFE000CE3 (beq -8) -> fmt=B, imm=0xFFFFFFF8. 0x123452B7 (lui x5) -> fmt=U, rd=5, imm=0x12345000.
- Backpressure:
  - Hold out_ready=0 and stream A, B, C.
  - A appears on the output and B goes to the skid entry; in_ready=0 the cycle after B's transfer, so C is not accepted.
  - Raise out_ready: outputs appear in order A, B, C, with no loss or duplication.
- Flush while FULL with in_valid=1: next cycle out_valid=0 and in_ready=1. The discarded input never appears on the output.
- 0x0000007F -> out_illegal=1, fmt=7, imm=0, func7=0. Assert rst mid-stream -> out_valid=0 and in_ready=1 the next cycle.
